// File: rtl/echo_delay_filter.sv
// N-channel echo/delay stage: one frame per LR-clock rising edge, per-channel circular delay RAM.
// Define ECHO_SATURATE_EN to clamp the output/feedback sample instead of wrapping it.
module echo_delay_filter #(
   parameter int SAMPLE_W = 16,
   parameter int NUM_CH   = 2,
   parameter int DELAY_AW = 10
) (
   input  logic                       AUDIO_CLK,
   input  logic                       rst,
   input  logic                       AUD_DACLRCK,
   input  logic [NUM_CH*SAMPLE_W-1:0] in_data,
   input  logic [DELAY_AW-1:0]        delay_len,
   input  logic [3:0]                 gain,
   input  logic                       fb_mode,
   output logic [NUM_CH*SAMPLE_W-1:0] out_data,
   output logic                       out_valid,
   output logic                       busy,
   output logic                       overrun
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int ACC_W = SAMPLE_W + 5;
   localparam int FRM_W = NUM_CH * SAMPLE_W;
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_DONE} state_t;

   state_t                     state_q, state_d;
   logic [CH_W-1:0]            ch_q, ch_d;
   logic                       lrck_q;
   logic                       start;
   logic [FRM_W-1:0]           x_q, frame_q, out_data_q;
   logic [DELAY_AW-1:0]        dly_q, wr_ptr_q, fill_q;
   logic [3:0]                 gain_q;
   logic                       fb_q;
   logic                       out_valid_q, overrun_q;
   logic signed [SAMPLE_W-1:0] rd_q, y_q, x_ch, d_w, y_w;
   logic signed [ACC_W-1:0]    prod_w, y_full;
   logic [CH_W+DELAY_AW-1:0]   rd_addr, wr_addr;
   logic                       mem_we;
   int                         slice_lo;
   logic signed [SAMPLE_W-1:0] mem [NUM_CH * (1 << DELAY_AW)];

   assign start = AUD_DACLRCK & ~lrck_q;
   assign busy  = rst & ((state_q != S_IDLE) | start);

   // Channel 0 lives in the most-significant slice of the packed frame.
   always_comb begin
      slice_lo = (NUM_CH - 1 - int'(ch_q)) * SAMPLE_W;
      x_ch     = x_q[slice_lo +: SAMPLE_W];
      rd_addr  = {ch_q, wr_ptr_q - dly_q};
      wr_addr  = {ch_q, wr_ptr_q};
   end

   // Echo path: taps older than the written history read as silence.
   always_comb begin
      d_w    = (dly_q == '0 || fill_q < dly_q) ? '0 : rd_q;
      prod_w = $signed(ACC_W'({1'b0, gain_q})) * ACC_W'(d_w);
      y_full = ACC_W'(x_ch) + (prod_w >>> 4);
`ifdef ECHO_SATURATE_EN
      if (y_full > ACC_W'(2 ** (SAMPLE_W - 1) - 1))
         y_w = {1'b0, {(SAMPLE_W-1){1'b1}}};
      else if (y_full < -ACC_W'(2 ** (SAMPLE_W - 1)))
         y_w = {1'b1, {(SAMPLE_W-1){1'b0}}};
      else
         y_w = y_full[SAMPLE_W-1:0];
`else
      y_w = y_full[SAMPLE_W-1:0];
`endif
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_RD;
            ch_d    = '0;
         end
         S_RD:   state_d = S_CALC;
         S_CALC: state_d = S_WR;
         S_WR: begin
            mem_we = 1'b1;
            if (ch_q == LAST_CH) begin
               state_d = S_DONE;
            end else begin
               ch_d    = ch_q + 1'b1;
               state_d = S_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge AUDIO_CLK or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ch_q        <= '0;
         lrck_q      <= 1'b0;
         x_q         <= '0;
         dly_q       <= '0;
         gain_q      <= '0;
         fb_q        <= 1'b0;
         y_q         <= '0;
         frame_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         lrck_q      <= AUD_DACLRCK;
         out_valid_q <= (state_q == S_DONE);
         if (start && state_q == S_IDLE) begin
            x_q    <= in_data;
            dly_q  <= delay_len;
            gain_q <= gain;
            fb_q   <= fb_mode;
         end
         if (start && state_q != S_IDLE)
            overrun_q <= 1'b1;
         if (state_q == S_CALC)
            y_q <= y_w;
         if (state_q == S_WR)
            frame_q[slice_lo +: SAMPLE_W] <= y_q;
         if (state_q == S_DONE) begin
            out_data_q <= frame_q;
            wr_ptr_q   <= wr_ptr_q + 1'b1;
            if (fill_q != '1)
               fill_q <= fill_q + 1'b1;
         end
      end
   end

   // Sample RAM is never cleared; the fill count hides stale contents.
   always_ff @(posedge AUDIO_CLK) begin
      if (mem_we)
         mem[wr_addr] <= fb_q ? y_q : x_ch;
      if (state_q == S_RD)
         rd_q <= mem[rd_addr];
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_echo_delay_filter.sv
// Bench for echo_delay_filter: frame-level reference model plus literal expectations feeding one scoreboard.
module tb_echo_delay_filter;
   localparam int SW = 16;
   localparam int NCH = 2;
   localparam int AW = 10;
   localparam int W = NCH * SW;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          lrck;
   logic [W-1:0]  in_data;
   logic [AW-1:0] delay_len;
   logic [3:0]    gain;
   logic          fb_mode;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          busy;
   logic          overrun;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int valid_cnt = 0;

   int cfg_dl = 0;
   int cfg_gain = 0;
   bit cfg_fb = 0;
   int m_mem[NCH][DEPTH];
   int m_wp = 0;
   int m_fill = 0;

   int ff_exp[9] = '{1000, 0, 0, 0, 750, 0, 0, 0, 0};
   int fb_exp[13] = '{1000, 0, 0, 0, 750, 0, 0, 0, 562, 0, 0, 0, 421};

   echo_delay_filter #(.SAMPLE_W(SW), .NUM_CH(NCH), .DELAY_AW(AW)) u_dut (
      .AUDIO_CLK   (clk),
      .rst         (rst),
      .AUD_DACLRCK (lrck),
      .in_data     (in_data),
      .delay_len   (delay_len),
      .gain        (gain),
      .fb_mode     (fb_mode),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_wp = 0;
      m_fill = 0;
   endtask

   // Frame-level reference: delay line per channel, fill-gated tap, gain/16 with floor.
   task automatic model_frame(input int x0, input int x1, output logic [W-1:0] y_pk);
      int x[NCH];
      int d, e, y;
      logic signed [SW-1:0] t;
      x[0] = x0;
      x[1] = x1;
      for (int c = 0; c < NCH; c++) begin
         d = (cfg_dl == 0 || m_fill < cfg_dl) ? 0 : m_mem[c][(m_wp - cfg_dl) & (DEPTH - 1)];
         e = (cfg_gain * d) >>> 4;
         y = x[c] + e;
`ifdef ECHO_SATURATE_EN
         if (y > 32767) y = 32767;
         else if (y < -32768) y = -32768;
`else
         t = y[SW-1:0];
         y = int'(t);
`endif
         m_mem[c][m_wp] = cfg_fb ? y : x[c];
         y_pk[(NCH-1-c)*SW +: SW] = 16'(y);
      end
      m_wp = (m_wp + 1) & (DEPTH - 1);
      if (m_fill < DEPTH - 1) m_fill++;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      lrck = 1'b0;
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   // Drives one frame, scrambles the live inputs mid-frame, and checks latency and busy width.
   task automatic send_frame(input int x0, input int x1, input bit use_lit, input int l0, input int l1);
      logic [W-1:0] mexp;
      int lat, busy_cnt;
      bit seen;
      model_frame(x0, x1, mexp);
      @(negedge clk);
      in_data = {16'(x0), 16'(x1)};
      delay_len = 10'(cfg_dl);
      gain = 4'(cfg_gain);
      fb_mode = cfg_fb;
      exp_q.push_back(use_lit ? {16'(l0), 16'(l1)} : mexp);
      lrck = 1'b1;
      #1;
      busy_cnt = busy ? 1 : 0;
      seen = 1'b0;
      lat = 0;
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(negedge clk);
         if (n == 2) begin
            delay_len = 10'($urandom);
            gain = 4'($urandom);
            fb_mode = 1'($urandom);
            in_data = $urandom;
         end
         busy_cnt += busy ? 1 : 0;
         if (out_valid) begin
            seen = 1'b1;
            lat = n;
         end
      end
      check_val("latency", lat, 8);
      check_val("busy_cycles", busy_cnt, 8);
      lrck = 1'b0;
   endtask

   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst && out_valid) begin
         valid_cnt++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_out_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_val("out_ch0", int'($signed(out_data[W-1:SW])), int'($signed(e[W-1:SW])));
            check_val("out_ch1", int'($signed(out_data[SW-1:0])), int'($signed(e[SW-1:0])));
         end
      end
   end

   initial begin
      logic [W-1:0] mexp;
      int v0, a, b, sat2;
      rst = 1'b0;
      lrck = 1'b0;
      in_data = '0;
      delay_len = '0;
      gain = '0;
      fb_mode = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_out_data", int'(out_data), 0);
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_overrun", int'(overrun), 0);
      rst = 1'b1;
      @(negedge clk);

      // Bypass: output equals input regardless of gain/mode.
      model_reset();
      cfg_dl = 0;
      for (int i = 0; i < 10; i++) begin
         cfg_gain = $urandom_range(15, 0);
         cfg_fb = 1'($urandom);
         a = int'($urandom_range(65535, 0)) - 32768;
         b = int'($urandom_range(65535, 0)) - 32768;
         send_frame(a, b, 1, a, b);
      end

      apply_reset();
      cfg_dl = 4; cfg_gain = 12; cfg_fb = 0;
      for (int i = 0; i < 9; i++) send_frame((i == 0) ? 1000 : 0, 0, 1, ff_exp[i], 0);

      apply_reset();
      cfg_dl = 4; cfg_gain = 12; cfg_fb = 1;
      for (int i = 0; i < 13; i++) send_frame((i == 0) ? 1000 : 0, 0, 1, fb_exp[i], 0);

`ifdef ECHO_SATURATE_EN
      sat2 = 32767;
`else
      sat2 = -7411;
`endif
      apply_reset();
      cfg_dl = 1; cfg_gain = 15; cfg_fb = 0;
      send_frame(30000, 0, 1, 30000, 0);
      send_frame(30000, 0, 1, sat2, 0);

      apply_reset();
      cfg_dl = $urandom_range(6, 1);
      cfg_gain = $urandom_range(15, 0);
      cfg_fb = 1'($urandom);
      for (int i = 0; i < 30; i++)
         send_frame(int'($urandom_range(40000, 0)) - 20000, int'($urandom_range(40000, 0)) - 20000, 0, 0, 0);

      // Second edge while busy: ignored, sticky overrun.
      apply_reset();
      check_val("overrun_clear", int'(overrun), 0);
      cfg_dl = 0; cfg_gain = 12; cfg_fb = 0;
      model_frame(1234, -99, mexp);
      exp_q.push_back(mexp);
      @(negedge clk);
      in_data = {16'(1234), 16'(-99)};
      delay_len = '0;
      gain = 4'(cfg_gain);
      fb_mode = 1'b0;
      v0 = valid_cnt;
      lrck = 1'b1;
      @(negedge clk) lrck = 1'b0;
      @(negedge clk);
      @(negedge clk) lrck = 1'b1;
      repeat (20) @(negedge clk);
      check_val("overrun_valid_pulses", valid_cnt - v0, 1);
      check_val("overrun_set", int'(overrun), 1);
      lrck = 1'b0;
      send_frame(5, 6, 1, 5, 6);
      check_val("overrun_sticky", int'(overrun), 1);

      // Reset in the middle of a frame.
      @(negedge clk);
      in_data = {16'(777), 16'(-777)};
      lrck = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("midrst_out_data", int'(out_data), 0);
      check_val("midrst_out_valid", int'(out_valid), 0);
      check_val("midrst_busy", int'(busy), 0);
      check_val("midrst_overrun", int'(overrun), 0);
      exp_q.delete();
      model_reset();
      lrck = 1'b0;
      @(negedge clk) rst = 1'b1;
      cfg_dl = $urandom_range(DEPTH - 1, 1);
      cfg_gain = 15;
      send_frame(-4321, 2468, 1, -4321, 2468);

      // Longest delay across the pointer wrap.
      apply_reset();
      cfg_dl = DEPTH - 1; cfg_gain = 12; cfg_fb = 0;
      for (int n = 0; n < DEPTH + 6; n++) send_frame(n * 13 - 5000, -(n * 7), 0, 0, 0);

      repeat (5) @(negedge clk);
      check_val("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
